// File: rtl/scrambler_pkg.sv
// Shared constants for the keystream scrambler: advance-rule encodings and default LFSR taps.
package scrambler_pkg;

   typedef enum logic [1:0] {
      MODE_DOWN = 2'b00,
      MODE_UP   = 2'b01,
      MODE_LFSR = 2'b10,
      MODE_HOLD = 2'b11
   } mode_e;

   localparam logic [7:0] DEFAULT_TAPS = 8'hB8;

endpackage

// File: rtl/keystream_next.sv
// Combinational next-keystream and counter-wrap computation for one advance step.
module keystream_next
   import scrambler_pkg::*;
#(
   parameter int                WIDTH     = 8,
   parameter logic [WIDTH-1:0]  LFSR_TAPS = WIDTH'(DEFAULT_TAPS)
) (
   input  logic [WIDTH-1:0] ks,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] ks_next,
   output logic             wrap_next
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   always_comb begin
      ks_next   = ks;
      wrap_next = 1'b0;
      case (mode)
         MODE_DOWN: begin
            ks_next   = ks - ONE;
            wrap_next = (ks == '0);
         end
         MODE_UP: begin
            ks_next   = ks + ONE;
            wrap_next = &ks;
         end
         MODE_LFSR: begin
            // An all-zero Galois register never leaves zero, so force it onto the sequence.
            if (ks == '0) ks_next = ONE;
            else          ks_next = (ks >> 1) ^ (ks[0] ? LFSR_TAPS : '0);
         end
         default: begin
            ks_next = ks;
         end
      endcase
   end

endmodule

// File: rtl/keystream_scrambler.sv
// XOR scrambler with a selectable-rule keystream; one registered output word per valid input.
module keystream_scrambler
   import scrambler_pkg::*;
#(
   parameter int                WIDTH     = 8,
   parameter logic [WIDTH-1:0]  LFSR_TAPS = WIDTH'(DEFAULT_TAPS),
   parameter logic [WIDTH-1:0]  RESET_KEY = '0
) (
   input  logic             clk,
   input  logic             clear_n,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] seed,
   input  logic [1:0]       mode,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] cct_input,
   output logic             out_valid,
   output logic [WIDTH-1:0] cct_output,
   output logic             wrap
);

   logic [WIDTH-1:0] ks;
   logic [WIDTH-1:0] ks_next;
   logic             wrap_next;

   keystream_next #(
      .WIDTH     (WIDTH),
      .LFSR_TAPS (LFSR_TAPS)
   ) u_next (
      .ks        (ks),
      .mode      (mode),
      .ks_next   (ks_next),
      .wrap_next (wrap_next)
   );

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         ks         <= RESET_KEY;
         cct_output <= '0;
         out_valid  <= 1'b0;
         wrap       <= 1'b0;
      end else if (clear) begin
         ks         <= '0;
         cct_output <= '0;
         out_valid  <= 1'b0;
         wrap       <= 1'b0;
      end else if (load) begin
         // A word presented alongside load is dropped; cct_output keeps the last word.
         ks         <= seed;
         out_valid  <= 1'b0;
         wrap       <= 1'b0;
      end else if (in_valid) begin
         ks         <= ks_next;
         cct_output <= cct_input ^ ks;
         out_valid  <= 1'b1;
         wrap       <= wrap_next;
      end else begin
         out_valid  <= 1'b0;
         wrap       <= 1'b0;
      end
   end

endmodule

// File: tb/tb_keystream_scrambler.sv
// Self-checking bench for keystream_scrambler: scoreboard of expected words, one task per scenario.
module tb_keystream_scrambler;

   logic       clk;
   logic       clear_n;
   logic       clear;
   logic       load;
   logic [7:0] seed;
   logic [1:0] mode;
   logic       in_valid;
   logic [7:0] cct_input;
   logic       out_valid;
   logic [7:0] cct_output;
   logic       wrap;

   typedef struct {
      logic [7:0] data;
      logic       wrap;
   } exp_t;

   exp_t       sb[$];
   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] tb_ks;

   keystream_scrambler #(.WIDTH(8)) dut (
      .clk        (clk),
      .clear_n    (clear_n),
      .clear      (clear),
      .load       (load),
      .seed       (seed),
      .mode       (mode),
      .in_valid   (in_valid),
      .cct_input  (cct_input),
      .out_valid  (out_valid),
      .cct_output (cct_output),
      .wrap       (wrap)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step_word(input logic [7:0] d, input logic [1:0] m,
                            output logic ov, output logic [7:0] od, output logic ow);
      in_valid  = 1'b1;
      cct_input = d;
      mode      = m;
      @(posedge clk);
      #1;
      ov = out_valid;
      od = cct_output;
      ow = wrap;
      in_valid = 1'b0;
   endtask

   task automatic do_load(input logic [7:0] s);
      load = 1'b1;
      seed = s;
      @(posedge clk);
      #1;
      load = 1'b0;
   endtask

   function automatic exp_t model_adv(input logic [1:0] m, input logic [7:0] d);
      exp_t e;
      e.data = d ^ tb_ks;
      e.wrap = 1'b0;
      case (m)
         2'b00: begin e.wrap = (tb_ks == 8'h00); tb_ks = tb_ks - 8'd1; end
         2'b01: begin e.wrap = (tb_ks == 8'hFF); tb_ks = tb_ks + 8'd1; end
         2'b10: begin
            if (tb_ks == 8'h00) tb_ks = 8'h01;
            else if (tb_ks[0])  tb_ks = {1'b0, tb_ks[7:1]} ^ 8'hB8;
            else                tb_ks = {1'b0, tb_ks[7:1]};
         end
         default: ;
      endcase
      return e;
   endfunction

   task automatic test_reset();
      clear_n = 1'b0; clear = 1'b0; load = 1'b0; seed = '0;
      mode = 2'b00; in_valid = 1'b0; cct_input = '0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || cct_output !== 8'h00 || wrap !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_state: got v=%b d=%h w=%b, expected v=0 d=00 w=0", out_valid, cct_output, wrap);
      end
      @(posedge clk);
      #1;
      clear_n = 1'b1;
   endtask

   task automatic test_down_wrap();
      logic ov, ow; logic [7:0] od; exp_t e;
      logic [7:0] din [2] = '{8'hAA, 8'hAA};
      sb.push_back('{8'hAA, 1'b1});
      sb.push_back('{8'h55, 1'b0});
      for (int i = 0; i < 2; i++) begin
         step_word(din[i], 2'b00, ov, od, ow);
         e = sb.pop_front();
         n_cmp++;
         if (ov !== 1'b1 || od !== e.data || ow !== e.wrap) begin
            n_bad++;
            $display("FAIL down_word%0d: got v=%b d=%h w=%b, expected v=1 d=%h w=%b", i, ov, od, ow, e.data, e.wrap);
         end
      end
   endtask

   task automatic test_up_wrap();
      logic ov, ow; logic [7:0] od; exp_t e;
      do_load(8'hFE);
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL load_valid: got v=%b, expected v=0", out_valid);
      end
      sb.push_back('{8'hFE, 1'b0});
      sb.push_back('{8'hFF, 1'b1});
      sb.push_back('{8'h00, 1'b0});
      sb.push_back('{8'h01, 1'b0});
      for (int i = 0; i < 4; i++) begin
         // The fourth word uses hold mode to expose the final keystream value.
         step_word(8'h00, (i == 3) ? 2'b11 : 2'b01, ov, od, ow);
         e = sb.pop_front();
         n_cmp++;
         if (ov !== 1'b1 || od !== e.data || ow !== e.wrap) begin
            n_bad++;
            $display("FAIL up_word%0d: got v=%b d=%h w=%b, expected v=1 d=%h w=%b", i, ov, od, ow, e.data, e.wrap);
         end
      end
   endtask

   task automatic test_lfsr();
      logic ov, ow; logic [7:0] od; exp_t e;
      logic [7:0] exp_seq [4] = '{8'h01, 8'hB8, 8'h5C, 8'h2E};
      do_load(8'h01);
      for (int i = 0; i < 4; i++) sb.push_back('{exp_seq[i], 1'b0});
      for (int i = 0; i < 4; i++) begin
         step_word(8'h00, 2'b10, ov, od, ow);
         e = sb.pop_front();
         n_cmp++;
         if (ov !== 1'b1 || od !== e.data || ow !== e.wrap) begin
            n_bad++;
            $display("FAIL lfsr_word%0d: got v=%b d=%h w=%b, expected v=1 d=%h w=%b", i, ov, od, ow, e.data, e.wrap);
         end
      end
      do_load(8'h00);
      sb.push_back('{8'h00, 1'b0});
      sb.push_back('{8'h01, 1'b0});
      for (int i = 0; i < 2; i++) begin
         step_word(8'h00, 2'b10, ov, od, ow);
         e = sb.pop_front();
         n_cmp++;
         if (ov !== 1'b1 || od !== e.data || ow !== e.wrap) begin
            n_bad++;
            $display("FAIL lfsr_lockup%0d: got v=%b d=%h w=%b, expected v=1 d=%h w=%b", i, ov, od, ow, e.data, e.wrap);
         end
      end
   endtask

   task automatic test_gaps();
      logic ov, ow; logic [7:0] od; exp_t e;
      logic [7:0] din [3] = '{8'h0F, 8'hF0, 8'h00};
      do_load(8'h10);
      sb.push_back('{8'h1F, 1'b0});
      sb.push_back('{8'hFF, 1'b0});
      sb.push_back('{8'h0E, 1'b0});
      for (int w = 0; w < 3; w++) begin
         step_word(din[w], 2'b00, ov, od, ow);
         e = sb.pop_front();
         n_cmp++;
         if (ov !== 1'b1 || od !== e.data || ow !== e.wrap) begin
            n_bad++;
            $display("FAIL gap_word%0d: got v=%b d=%h w=%b, expected v=1 d=%h w=%b", w, ov, od, ow, e.data, e.wrap);
         end
         for (int g = 0; g < 3; g++) begin
            cct_input = 8'h5A;
            @(posedge clk);
            #1;
            n_cmp++;
            if (out_valid !== 1'b0 || cct_output !== e.data || wrap !== 1'b0) begin
               n_bad++;
               $display("FAIL gap_idle%0d_%0d: got v=%b d=%h w=%b, expected v=0 d=%h w=0", w, g, out_valid, cct_output, wrap, e.data);
            end
         end
      end
   endtask

   task automatic test_clear_load();
      logic ov, ow; logic [7:0] od; exp_t e;
      do_load(8'h33);
      sb.push_back('{8'h33, 1'b0});
      step_word(8'h00, 2'b01, ov, od, ow);
      e = sb.pop_front();
      n_cmp++;
      if (ov !== 1'b1 || od !== e.data || ow !== e.wrap) begin
         n_bad++;
         $display("FAIL preclear_word: got v=%b d=%h w=%b, expected v=1 d=%h w=%b", ov, od, ow, e.data, e.wrap);
      end
      clear = 1'b1; load = 1'b1; seed = 8'h77; in_valid = 1'b1; cct_input = 8'hFF; mode = 2'b01;
      @(posedge clk);
      #1;
      clear = 1'b0; load = 1'b0; in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0 || cct_output !== 8'h00 || wrap !== 1'b0) begin
         n_bad++;
         $display("FAIL clear_load: got v=%b d=%h w=%b, expected v=0 d=00 w=0", out_valid, cct_output, wrap);
      end
      sb.push_back('{8'h5A, 1'b0});
      step_word(8'h5A, 2'b11, ov, od, ow);
      e = sb.pop_front();
      n_cmp++;
      if (ov !== 1'b1 || od !== e.data || ow !== e.wrap) begin
         n_bad++;
         $display("FAIL postclear_word: got v=%b d=%h w=%b, expected v=1 d=%h w=%b", ov, od, ow, e.data, e.wrap);
      end
   endtask

   task automatic test_async_reset();
      logic ov, ow; logic [7:0] od; exp_t e;
      do_load(8'h20);
      sb.push_back('{8'h20, 1'b0});
      step_word(8'h00, 2'b01, ov, od, ow);
      e = sb.pop_front();
      n_cmp++;
      if (ov !== 1'b1 || od !== e.data || ow !== e.wrap) begin
         n_bad++;
         $display("FAIL prereset_word: got v=%b d=%h w=%b, expected v=1 d=%h w=%b", ov, od, ow, e.data, e.wrap);
      end
      in_valid = 1'b1; cct_input = 8'h11; mode = 2'b01;
      #2;
      clear_n = 1'b0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || cct_output !== 8'h00 || wrap !== 1'b0) begin
         n_bad++;
         $display("FAIL async_reset_now: got v=%b d=%h w=%b, expected v=0 d=00 w=0", out_valid, cct_output, wrap);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      clear_n  = 1'b1;
      @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || cct_output !== 8'h00 || wrap !== 1'b0) begin
         n_bad++;
         $display("FAIL async_reset_idle: got v=%b d=%h w=%b, expected v=0 d=00 w=0", out_valid, cct_output, wrap);
      end
      sb.push_back('{8'h3C, 1'b1});
      step_word(8'h3C, 2'b00, ov, od, ow);
      e = sb.pop_front();
      n_cmp++;
      if (ov !== 1'b1 || od !== e.data || ow !== e.wrap) begin
         n_bad++;
         $display("FAIL postreset_word: got v=%b d=%h w=%b, expected v=1 d=%h w=%b", ov, od, ow, e.data, e.wrap);
      end
   endtask

   task automatic test_back_to_back();
      logic ov, ow; logic [7:0] od; exp_t e;
      logic [7:0] d; logic [1:0] m;
      do_load(8'hC3);
      tb_ks = 8'hC3;
      for (int i = 0; i < 48; i++) begin
         d = 8'($urandom_range(0, 255));
         m = 2'($urandom_range(0, 3));
         if (i < 4) tb_ks = tb_ks;
         sb.push_back(model_adv(m, d));
         step_word(d, m, ov, od, ow);
         if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL b2b_empty%0d: got empty scoreboard, expected one entry", i);
         end else begin
            e = sb.pop_front();
            n_cmp++;
            if (ov !== 1'b1 || od !== e.data || ow !== e.wrap) begin
               n_bad++;
               $display("FAIL b2b_word%0d: got v=%b d=%h w=%b, expected v=1 d=%h w=%b (mode %b)", i, ov, od, ow, e.data, e.wrap, m);
            end
         end
      end
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL sb_drain: got %0d entries left, expected 0", sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_down_wrap();
      test_up_wrap();
      test_lfsr();
      test_gaps();
      test_clear_load();
      test_async_reset();
      test_back_to_back();
      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/keystream_scrambler.md
KEYSTREAM_SCRAMBLER -- requirements
Module: keystream_scrambler

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data, seed and keystream width (WIDTH >= 2).
REQ-002 Parameter LFSR_TAPS, default 8'hB8 (WIDTH bits), SHALL set the Galois LFSR feedback mask.
REQ-003 Parameter RESET_KEY, default 0, SHALL set the keystream value loaded on reset.
REQ-004 Port clk, input, 1, SHALL be the single clock; all state changes on its rising edge.
REQ-005 Port clear_n, input, 1, SHALL be the reset, asynchronous and active-low.
REQ-006 Port clear, input, 1, SHALL be a synchronous active-high clear.
REQ-007 Port load, input, 1, SHALL be a synchronous seed-load strobe.
REQ-008 Port seed, input, WIDTH, SHALL be the keystream value taken on load.
REQ-009 Port mode, input, 2, SHALL select the advance rule: 00 down, 01 up, 10 LFSR, 11 hold.
REQ-010 Port in_valid, input, 1, SHALL qualify cct_input.
REQ-011 Port cct_input, input, WIDTH, SHALL be the data word to scramble.
REQ-012 Port out_valid, output, 1, SHALL qualify cct_output.
REQ-013 Port cct_output, output, WIDTH, SHALL be the registered scrambled word.
REQ-014 Port wrap, output, 1, SHALL flag that the word on cct_output caused a counter wrap.

Function
REQ-015 Keystream register ks (WIDTH bits) SHALL update with priority: clear_n low > clear > load > advance > hold.
REQ-016 clear SHALL set ks to 0 and set out_valid, wrap and cct_output to 0 on the next edge.
REQ-017 load (clear low) SHALL set ks to seed and out_valid to 0; in_valid in that cycle SHALL be dropped.
REQ-018 Advance SHALL occur only in cycles with in_valid=1, clear=0, load=0; otherwise ks holds.
REQ-019 In an advance cycle, cct_output SHALL become cct_input XOR ks (pre-advance value), and out_valid 1, one cycle later (latency 1).
REQ-020 In cycles without advance, clear or load, out_valid SHALL be 0 next cycle; cct_output SHALL hold its value.
REQ-021 mode 00 SHALL set ks to ks-1 modulo 2^WIDTH; 0 -> all-ones SHALL set wrap=1 with that word.
REQ-022 mode 01 SHALL set ks to ks+1 modulo 2^WIDTH; all-ones -> 0 SHALL set wrap=1 with that word.
REQ-023 mode 10 SHALL set ks to (ks>>1) XOR (ks[0] ? LFSR_TAPS : 0); ks==0 SHALL advance to 1 (lock-up escape); wrap SHALL be 0.
REQ-024 mode 11 SHALL keep ks unchanged while still scrambling and emitting out_valid; wrap SHALL be 0.
REQ-025 mode SHALL be sampled in the advance cycle only; mode changes between words need no flush.
REQ-026 wrap SHALL be 0 whenever out_valid is 0.

Reset
REQ-027 clear_n low SHALL immediately, without a clock edge, force ks=RESET_KEY, cct_output=0, out_valid=0, wrap=0.
REQ-028 clear_n deassertion SHALL be synchronised to clk externally; the block adds no reset synchroniser.
REQ-029 Reset mid-stream SHALL discard the in-flight word; no output from before reset SHALL reappear.

Structure
REQ-030 Package scrambler_pkg SHALL hold the mode encoding constants (MODE_DOWN, MODE_UP, MODE_LFSR, MODE_HOLD) and the default tap constant.
REQ-031 Sub-module keystream_next SHALL compute next ks and wrap combinationally from ks, mode and LFSR_TAPS; the top holds all registers.

Verification (WIDTH=8, defaults)
REQ-032 Reset, mode=00, in_valid with 8'hAA twice -> cct_output 8'hAA (wrap=1), then 8'h55 (wrap=0), out_valid 1 each.
REQ-033 load seed 8'hFE, mode=01, three inputs 8'h00 -> outputs FE, FF (wrap=1), 00; ks ends 8'h01.
REQ-034 load seed 8'h01, mode=10, four inputs 8'h00 -> outputs 01, B8, 5C, 2E; load seed 0, input 00 -> output 00, next output 01.
REQ-035 in_valid gaps of 3 cycles between words in mode 00 -> ks unchanged across gaps, out_valid 0 in gap cycles, cct_output held.
REQ-036 clear and load high together with in_valid -> ks=0, out_valid=0, cct_output=0; no word emitted.
REQ-037 clear_n pulsed low between clock edges mid-stream -> outputs 0 at once; first word after release XORed with RESET_KEY.
